// File: rtl/core_rvfi_checker.sv
// rtl/core_rvfi_checker.sv - RVFI retirement trace consistency checker
module core_rvfi_checker #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            rvfi_valid,
  input  logic [63:0]     rvfi_order,
  input  logic [ILEN-1:0] rvfi_insn,
  input  logic            rvfi_trap,
  input  logic            rvfi_intr,
  input  logic            rvfi_halt,
  input  logic [4:0]      rvfi_rs1_addr,
  input  logic [4:0]      rvfi_rs2_addr,
  input  logic [XLEN-1:0] rvfi_rs1_rdata,
  input  logic [XLEN-1:0] rvfi_rs2_rdata,
  input  logic [4:0]      rvfi_rd_addr,
  input  logic [XLEN-1:0] rvfi_rd_wdata,
  input  logic [XLEN-1:0] rvfi_pc_rdata,
  input  logic [XLEN-1:0] rvfi_pc_wdata,
  output logic            err_valid,
  output logic [6:0]      err_code,
  output logic [6:0]      err_flags,
  output logic [63:0]     err_order,
  output logic [63:0]     retire_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_e;

  state_e          state_q, state_d;
  logic [63:0]     exp_order_q;
  logic [XLEN-1:0] exp_pc_q;
  logic [31:0]     shadow_vld_q;
  logic [XLEN-1:0] shadow_q [32];
  logic            err_valid_q, err_valid_d;
  logic [6:0]      err_code_q;
  logic [6:0]      err_flags_q;
  logic [63:0]     err_order_q;
  logic [63:0]     retire_count_q;
  logic [6:0]      chk;
  logic            rs1_bad, rs2_bad, rd_write;

  // The instruction word is carried on the trace for debug only.
  logic unused_insn;
  assign unused_insn = ^rvfi_insn;

  assign rd_write = rvfi_valid && !rvfi_trap && (rvfi_rd_addr != 5'd0);

  // Per-retirement checks, all against state from before this retirement.
  always_comb begin
    rs1_bad = 1'b0;
    rs2_bad = 1'b0;
    if (rvfi_rs1_addr == 5'd0) rs1_bad = (rvfi_rs1_rdata != '0);
    else rs1_bad = shadow_vld_q[rvfi_rs1_addr] && (rvfi_rs1_rdata != shadow_q[rvfi_rs1_addr]);
    if (rvfi_rs2_addr == 5'd0) rs2_bad = (rvfi_rs2_rdata != '0);
    else rs2_bad = shadow_vld_q[rvfi_rs2_addr] && (rvfi_rs2_rdata != shadow_q[rvfi_rs2_addr]);
    chk    = '0;
    chk[0] = (state_q == RUN) && (rvfi_order != exp_order_q);
    chk[1] = (state_q == RUN) && !rvfi_intr && (rvfi_pc_rdata != exp_pc_q);
    chk[2] = rs1_bad;
    chk[3] = rs2_bad;
    chk[4] = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
    chk[5] = rvfi_pc_wdata[0] && !rvfi_trap;
    chk[6] = (state_q == HALTED);
    err_valid_d = rvfi_valid && (chk != 7'd0);
  end

  // Next-state: first retirement starts the run, a halting retirement parks for good.
  always_comb begin
    state_d = state_q;
    if (rvfi_valid) begin
      if (rvfi_halt || state_q == HALTED) state_d = HALTED;
      else state_d = RUN;
    end
  end

  // Tracking state and error reporting; a failing retirement still reseeds expectations.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q        <= IDLE;
      exp_order_q    <= '0;
      exp_pc_q       <= '0;
      shadow_vld_q   <= '0;
      err_valid_q    <= 1'b0;
      err_code_q     <= '0;
      err_flags_q    <= '0;
      err_order_q    <= '0;
      retire_count_q <= '0;
    end else begin
      state_q     <= state_d;
      err_valid_q <= err_valid_d;
      if (rvfi_valid) begin
        exp_order_q    <= rvfi_order + 64'd1;
        exp_pc_q       <= rvfi_pc_wdata;
        retire_count_q <= retire_count_q + 64'd1;
        err_flags_q    <= err_flags_q | chk;
        if (rd_write) shadow_vld_q[rvfi_rd_addr] <= 1'b1;
      end
      if (err_valid_d) begin
        err_code_q  <= chk;
        err_order_q <= rvfi_order;
      end
    end
  end

  // Shadow register values; only trusted where the matching valid bit is set.
  always_ff @(posedge g_clk) begin
    if (rd_write) shadow_q[rvfi_rd_addr] <= rvfi_rd_wdata;
  end

  assign err_valid    = err_valid_q;
  assign err_code     = err_code_q;
  assign err_flags    = err_flags_q;
  assign err_order    = err_order_q;
  assign retire_count = retire_count_q;

endmodule

// File: tb/tb_core_rvfi_checker.sv
// tb/tb_core_rvfi_checker.sv - self-checking bench for core_rvfi_checker
module tb_core_rvfi_checker;

  logic        g_clk = 1'b0;
  logic        g_resetn = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0;
  logic        rvfi_trap = 1'b0, rvfi_intr = 1'b0, rvfi_halt = 1'b0;
  logic [4:0]  rvfi_rs1_addr = '0, rvfi_rs2_addr = '0, rvfi_rd_addr = '0;
  logic [63:0] rvfi_rs1_rdata = '0, rvfi_rs2_rdata = '0, rvfi_rd_wdata = '0;
  logic [63:0] rvfi_pc_rdata = '0, rvfi_pc_wdata = '0;
  logic        err_valid;
  logic [6:0]  err_code, err_flags;
  logic [63:0] err_order, retire_count;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: architectural view of the trace so far.
  bit          m_started, m_halted;
  logic [63:0] m_order, m_pc, m_count, m_last_order;
  logic [6:0]  m_flags, m_last_code;
  bit          m_evalid;
  logic [63:0] m_reg [int];

  core_rvfi_checker #(.XLEN(64), .ILEN(32)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .rvfi_halt(rvfi_halt),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .err_valid(err_valid), .err_code(err_code), .err_flags(err_flags),
    .err_order(err_order), .retire_count(retire_count)
  );

  always #5 g_clk = ~g_clk;

  task automatic model_clear();
    m_started = 0; m_halted = 0; m_order = '0; m_pc = '0; m_count = '0;
    m_last_order = '0; m_flags = '0; m_last_code = '0; m_evalid = 0;
    m_reg.delete();
  endtask

  function automatic bit src_bad(input logic [4:0] a, input logic [63:0] d);
    if (a == 0) return d != 0;
    if (m_reg.exists(int'(a))) return m_reg[int'(a)] != d;
    return 0;
  endfunction

  // Present the current fields as one retirement; returns at the following negedge.
  task automatic ret();
    logic [6:0] c;
    c = '0;
    c[0] = m_started && !m_halted && (rvfi_order != m_order);
    c[1] = m_started && !m_halted && !rvfi_intr && (rvfi_pc_rdata != m_pc);
    c[2] = src_bad(rvfi_rs1_addr, rvfi_rs1_rdata);
    c[3] = src_bad(rvfi_rs2_addr, rvfi_rs2_rdata);
    c[4] = (rvfi_rd_addr == 0) && (rvfi_rd_wdata != 0);
    c[5] = rvfi_pc_wdata[0] && !rvfi_trap;
    c[6] = m_halted;
    m_started = 1;
    if (rvfi_halt) m_halted = 1;
    m_order = rvfi_order + 1;
    m_pc = rvfi_pc_wdata;
    m_count = m_count + 1;
    m_flags = m_flags | c;
    m_evalid = (c != 0);
    if (c != 0) begin m_last_code = c; m_last_order = rvfi_order; end
    if (!rvfi_trap && rvfi_rd_addr != 0) m_reg[int'(rvfi_rd_addr)] = rvfi_rd_wdata;
    rvfi_valid = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  task automatic idle();
    rvfi_valid = 1'b0;
    m_evalid = 0;
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  task automatic clean(input logic [63:0] o, input logic [63:0] pr, input logic [63:0] pw);
    rvfi_order = o; rvfi_pc_rdata = pr; rvfi_pc_wdata = pw; rvfi_insn = $urandom;
    rvfi_trap = 0; rvfi_intr = 0; rvfi_halt = 0;
    rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rd_addr = 0;
    rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0; rvfi_rd_wdata = 0;
  endtask

  task automatic do_reset();
    rvfi_valid = 1'b0;
    g_resetn = 1'b0;
    model_clear();
    @(negedge g_clk);
    @(negedge g_clk);
    g_resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_err_valid got %b exp 0", err_valid); end
    n_checks++; if (err_code !== 7'd0) begin n_fail++; $display("FAIL reset_err_code got %h exp 0", err_code); end
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL reset_err_flags got %h exp 0", err_flags); end
    n_checks++; if (err_order !== 64'd0) begin n_fail++; $display("FAIL reset_err_order got %h exp 0", err_order); end
    n_checks++; if (retire_count !== 64'd0) begin n_fail++; $display("FAIL reset_retire_count got %h exp 0", retire_count); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clean(64'd5 + i, 64'h1000 + 4 * i, 64'h1004 + 4 * i);
      ret();
      n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL seq_err_valid[%0d] got %b exp 0", i, err_valid); end
    end
    idle();
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL seq_err_flags got %h exp 0", err_flags); end
    n_checks++; if (retire_count !== 64'd3) begin n_fail++; $display("FAIL seq_retire_count got %0d exp 3", retire_count); end
  endtask

  task automatic test_order_gap();
    do_reset();
    clean(64'd10, 64'h100, 64'h104); ret();
    clean(64'd12, 64'h104, 64'h108); ret();
    n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL gap_err_valid got %b exp 1", err_valid); end
    n_checks++; if (err_code !== 7'b0000001) begin n_fail++; $display("FAIL gap_err_code got %b exp 0000001", err_code); end
    n_checks++; if (err_order !== 64'd12) begin n_fail++; $display("FAIL gap_err_order got %0d exp 12", err_order); end
    clean(64'd13, 64'h108, 64'h10c); ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL gap_no_cascade got %b exp 0", err_valid); end
    idle();
    n_checks++; if (err_code !== 7'b0000001) begin n_fail++; $display("FAIL gap_code_hold got %b exp 0000001", err_code); end
  endtask

  task automatic test_shadow();
    do_reset();
    clean(0, 0, 4); rvfi_rd_addr = 5; rvfi_rd_wdata = 64'hDEAD; ret();
    clean(1, 4, 8); rvfi_rs1_addr = 5; rvfi_rs1_rdata = 64'hBEEF; ret();
    n_checks++; if (err_code !== 7'b0000100 || err_valid !== 1'b1) begin n_fail++; $display("FAIL shadow_rs1_bad got %b/%b exp 1/0000100", err_valid, err_code); end
    clean(2, 8, 12); rvfi_rs1_addr = 5; rvfi_rs1_rdata = 64'hDEAD; ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL shadow_rs1_ok got %b exp 0", err_valid); end
    clean(3, 12, 16); rvfi_rs2_addr = 5; rvfi_rs2_rdata = 64'hDEAD; rvfi_rd_addr = 5; rvfi_rd_wdata = 64'h1111; ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL shadow_self_read got %b exp 0", err_valid); end
    clean(4, 16, 20); rvfi_rs2_addr = 5; rvfi_rs2_rdata = 64'hDEAD; ret();
    n_checks++; if (err_code !== 7'b0001000 || err_valid !== 1'b1) begin n_fail++; $display("FAIL shadow_new_value got %b/%b exp 1/0001000", err_valid, err_code); end
    idle();
  endtask

  task automatic test_unwritten();
    do_reset();
    clean(0, 0, 4); rvfi_rs2_addr = 7; rvfi_rs2_rdata = 64'h1234; ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL unwritten_valid got %b exp 0", err_valid); end
    idle();
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL unwritten_flags got %b exp 0", err_flags); end
  endtask

  task automatic test_pc_intr();
    do_reset();
    clean(0, 0, 64'h2000); ret();
    clean(1, 64'h3000, 64'h3004); rvfi_intr = 1; ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL pc_intr got %b exp 0", err_valid); end
    clean(2, 64'h4000, 64'h4004); ret();
    n_checks++; if (err_code !== 7'b0000010 || err_valid !== 1'b1) begin n_fail++; $display("FAIL pc_jump got %b/%b exp 1/0000010", err_valid, err_code); end
    idle();
  endtask

  task automatic test_rd_zero_align();
    do_reset();
    clean(0, 0, 4); rvfi_rd_wdata = 1; ret();
    n_checks++; if (err_code !== 7'b0010000 || err_valid !== 1'b1) begin n_fail++; $display("FAIL rd_zero got %b/%b exp 1/0010000", err_valid, err_code); end
    clean(1, 4, 5); ret();
    n_checks++; if (err_code !== 7'b0100000 || err_valid !== 1'b1) begin n_fail++; $display("FAIL pc_align got %b/%b exp 1/0100000", err_valid, err_code); end
    clean(2, 5, 9); rvfi_trap = 1; ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL pc_align_trap got %b exp 0", err_valid); end
    idle();
  endtask

  task automatic test_halt();
    do_reset();
    clean(0, 0, 4); rvfi_halt = 1; ret();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL halt_self got %b exp 0", err_valid); end
    clean(1, 4, 8); ret();
    n_checks++; if (err_code !== 7'b1000000 || err_valid !== 1'b1) begin n_fail++; $display("FAIL post_halt got %b/%b exp 1/1000000", err_valid, err_code); end
    idle(); idle();
    n_checks++; if (err_flags[6] !== 1'b1) begin n_fail++; $display("FAIL halt_sticky got %b exp 1", err_flags[6]); end
  endtask

  task automatic test_reset_midtrace();
    do_reset();
    clean(0, 0, 4); rvfi_halt = 1; rvfi_rd_wdata = 3; ret();
    rvfi_valid = 1'b0;
    #2 g_resetn = 1'b0;
    model_clear();
    #1;
    n_checks++; if (err_flags !== 7'd0 || retire_count !== 64'd0 || err_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_clear got %b/%0d/%b exp 0/0/0", err_flags, retire_count, err_valid); end
    @(negedge g_clk);
    g_resetn = 1'b1;
    clean({$urandom, $urandom}, {$urandom, 2'b00}, 64'h8000); ret();
    n_checks++; if (err_valid !== 1'b0 || retire_count !== 64'd1) begin n_fail++; $display("FAIL midreset_next got %b/%0d exp 0/1", err_valid, retire_count); end
    idle();
  endtask

  task automatic test_back_to_back_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rvfi_order     = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : m_order;
      rvfi_pc_rdata  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : m_pc;
      rvfi_pc_wdata  = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : {$urandom, $urandom} & ~64'd3;
      rvfi_intr      = ($urandom_range(0, 9) == 0);
      rvfi_trap      = ($urandom_range(0, 9) == 0);
      rvfi_halt      = ($urandom_range(0, 149) == 0);
      rvfi_insn      = $urandom;
      rvfi_rs1_addr  = 5'($urandom_range(0, 7));
      rvfi_rs2_addr  = 5'($urandom_range(0, 7));
      rvfi_rd_addr   = 5'($urandom_range(0, 7));
      rvfi_rs1_rdata = (rvfi_rs1_addr == 0) ? 64'd0 : m_reg.exists(int'(rvfi_rs1_addr)) ? m_reg[int'(rvfi_rs1_addr)] : {$urandom, $urandom};
      rvfi_rs2_rdata = (rvfi_rs2_addr == 0) ? 64'd0 : m_reg.exists(int'(rvfi_rs2_addr)) ? m_reg[int'(rvfi_rs2_addr)] : {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rvfi_rs1_rdata = rvfi_rs1_rdata ^ 64'd1;
      if ($urandom_range(0, 7) == 0) rvfi_rs2_rdata = rvfi_rs2_rdata ^ 64'h100;
      rvfi_rd_wdata  = (rvfi_rd_addr == 0 && $urandom_range(0, 7) != 0) ? 64'd0 : {$urandom, $urandom};
      ret();
      n_checks++; if (err_valid !== m_evalid) begin n_fail++; $display("FAIL rnd_err_valid[%0d] got %b exp %b", i, err_valid, m_evalid); end
      n_checks++; if (err_code !== m_last_code) begin n_fail++; $display("FAIL rnd_err_code[%0d] got %b exp %b", i, err_code, m_last_code); end
      n_checks++; if (err_flags !== m_flags) begin n_fail++; $display("FAIL rnd_err_flags[%0d] got %b exp %b", i, err_flags, m_flags); end
      n_checks++; if (err_order !== m_last_order) begin n_fail++; $display("FAIL rnd_err_order[%0d] got %h exp %h", i, err_order, m_last_order); end
      n_checks++; if (retire_count !== m_count) begin n_fail++; $display("FAIL rnd_retire_count[%0d] got %0d exp %0d", i, retire_count, m_count); end
      if ($urandom_range(0, 3) == 0) begin
        idle();
        n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_idle_valid[%0d] got %b exp 0", i, err_valid); end
      end
    end
    idle();
  endtask

  initial begin
    model_clear();
    @(negedge g_clk);
    test_reset();
    test_sequential();
    test_order_gap();
    test_shadow();
    test_unwritten();
    test_pc_intr();
    test_rd_zero_align();
    test_halt();
    test_reset_midtrace();
    test_back_to_back_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_rvfi_checker.md
Name: core_rvfi_checker

Overview:
- Consumer end of the core's RVFI retirement trace, for simulation and formal benches only; it does not exist in synthesised builds.
- Samples every retirement the core publishes on the RVFI interface.
- Maintains a shadow register file, the expected next PC and the expected next order value.
- Flags any trace that is inconsistent with the instruction stream seen so far, via a registered error pulse, sticky error flags and a retire counter.

Parameters:
- XLEN, 64, architectural register width.
- ILEN, 32, instruction word width.

Ports:
- g_clk  in  1  core clock.
- g_resetn  in  1  asynchronous active-low reset.
- rvfi_valid  in  1  retirement valid.
- rvfi_order  in  64  retirement sequence number.
- rvfi_insn  in  ILEN  retired instruction word, informational only.
- rvfi_trap  in  1  retirement trapped.
- rvfi_intr  in  1  first instruction of a trap handler.
- rvfi_halt  in  1  core halted after this retirement.
- rvfi_rs1_addr, rvfi_rs2_addr  in  5  source register indices.
- rvfi_rs1_rdata, rvfi_rs2_rdata  in  XLEN  source register values.
- rvfi_rd_addr  in  5  destination register index.
- rvfi_rd_wdata  in  XLEN  destination register write data.
- rvfi_pc_rdata, rvfi_pc_wdata  in  XLEN  PC of this instruction / next PC.
- err_valid  out  1  one-cycle pulse: the previous retirement failed at least one check.
- err_code  out  7  check failures for that retirement.
- err_flags  out  7  sticky OR of all err_code values since reset.
- err_order  out  64  rvfi_order of the most recent failing retirement.
- retire_count  out  64  number of retirements accepted since reset.

Behaviour:
- Reset: all outputs, state, expected order, expected PC and the 32 shadow-valid bits clear to 0 asynchronously. Shadow data storage is not reset.
- Reset mid-trace: reset discards all history; the next retirement is treated as the first.
- State machine states:
  - IDLE, entered on reset.
  - RUN, entered on the first rvfi_valid.
  - HALTED, entered on any retirement with rvfi_halt=1; left only by reset.
- A retirement is sampled on any posedge g_clk with rvfi_valid=1.
- Check latency is one cycle: err_valid, err_code and err_order update on the next edge. err_code holds its value while err_valid=0.
- err_code bit assignments (all evaluated on the same retirement):
  - [0] order: state RUN and rvfi_order != expected order.
  - [1] pc: state RUN, rvfi_intr=0 and rvfi_pc_rdata != expected PC.
  - [2] rs1: rs1_addr=0 with rs1_rdata!=0, or rs1_addr!=0 with its shadow-valid bit set and rs1_rdata != shadow[rs1_addr].
  - [3] rs2: as [2] for rs2.
  - [4] rd zero: rd_addr=0 and rd_wdata!=0.
  - [5] pc align: rvfi_pc_wdata[0]=1 and rvfi_trap=0.
  - [6] post-halt: rvfi_valid=1 while in state HALTED.
- In IDLE, checks [0] and [1] are not evaluated; the first retirement only seeds the expected values.
- The HALTED retirement itself is checked normally.
- err_valid=1 iff err_code is non-zero for that retirement.
- err_flags |= err_code on every sampled retirement.
- State updates on every sampled retirement:
  - Expected order = rvfi_order+1 (64-bit wrap).
  - Expected PC = rvfi_pc_wdata.
  - retire_count += 1 (64-bit wrap).
- Shadow update: when rvfi_trap=0 and rd_addr!=0, shadow[rd_addr] = rd_wdata and its valid bit is set.
- Same-retirement read/write: source checks compare against shadow state from before this retirement's write, so an instruction reading its own rd sees the old value.
- Unwritten registers (valid bit clear) are never compared.
- Back-to-back retirements (rvfi_valid high every cycle) are fully supported with no stall; there is no backpressure.
- Errors never stop checking. A failing retirement still updates all expected state from its own fields, so a single fault reports once and does not cascade.

Test Plan:
- Reset, then retirements order 5,6,7 with consistent PCs 0x1000→0x1004→0x1008 -> err_flags=0, retire_count=3, err_valid never high.
- Retire order 10, then order 12 -> err_valid pulses one cycle after the second retirement; err_code=7'b0000001, err_order=12.
- Retire `addi x5` with rd_wdata=0xDEAD, then a retirement with rs1_addr=5, rs1_rdata=0xBEEF -> err_code[2]=1.
- Same as previous but rs1_rdata=0xDEAD, back-to-back cycles -> no error.
- First instruction reads x7, never written, rs2_rdata=0x1234 -> no error.
- Retire pc_wdata=0x2000, then pc_rdata=0x3000 with rvfi_intr=1 -> no error; repeat with intr=0 -> err_code[1]=1.
- Retire with rd_addr=0, rd_wdata=1 -> err_code[4]=1.
- Retire with rvfi_halt=1, then one more retirement -> err_code[6]=1, err_flags[6] remains set.
- Assert g_resetn low between two valid retirements -> flags, counter and state clear immediately; the next retirement with an arbitrary order/PC reports no error.
